// File: rtl/fpga_ps_loader.sv
// fpga_ps_loader: passive-serial ACEX1K configuration engine fed by Z80 config-port byte writes
module fpga_ps_loader #(
  parameter int CLKDIV      = 2,
  parameter int NCFG_CYCLES = 64,
  parameter int STATUS_TMO  = 65535,
  parameter int INIT_CLKS   = 16
) (
  input  logic       clkin,
  input  logic       coldres,
  input  logic       start,
  input  logic       wr_stb,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       config_n,
  input  logic       status_n,
  input  logic       conf_done,
  output logic       dclk,
  output logic       data0,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] stat
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] NCFG   = 3'd1;
  localparam logic [2:0] WAITST = 3'd2;
  localparam logic [2:0] LOAD   = 3'd3;
  localparam logic [2:0] SHIFT  = 3'd4;
  localparam logic [2:0] FLUSH  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERROR  = 3'd7;
  localparam logic [15:0] HALF_END = 16'(CLKDIV - 1);
  localparam logic [15:0] NCFG_END = 16'(NCFG_CYCLES - 1);
  localparam logic [15:0] TMO_END  = 16'(STATUS_TMO - 1);
  localparam logic [15:0] INIT_END = 16'(INIT_CLKS - 1);
  logic [2:0]  state;
  logic [15:0] cnt, idx;
  logic        phase;
  logic [7:0]  shreg, f0, f1;
  logic [1:0]  fcnt, wr_pos;
  logic        overrun, st_m, st_s, cd_m, cd_s;
  logic        half_end, pop, push;
  // Handshake and FIFO control derived from current state
  always_comb begin
    half_end = cnt == HALF_END;
    wr_ready = (state == LOAD || state == SHIFT) && fcnt != 2'd2;
    push     = wr_stb && wr_ready && !start;
    pop      = st_s && !cd_s && !start && fcnt != 2'd0 &&
               (state == LOAD || (state == SHIFT && phase && half_end && idx == 16'd7));
    wr_pos   = fcnt - {1'b0, pop};
    config_n = state != NCFG;
    busy     = state inside {NCFG, WAITST, LOAD, SHIFT, FLUSH};
    done     = state == DONE;
    error    = state == ERROR;
    stat     = {st_s, cd_s, overrun, error, done, busy, fcnt};
  end
  // Two-flop synchronisers for the FPGA status pins
  always_ff @(posedge clkin) begin
    if (coldres) {st_m, st_s, cd_m, cd_s} <= 4'b0;
    else {st_m, st_s, cd_m, cd_s} <= {status_n, st_m, conf_done, cd_m};
  end
  // Two-entry byte FIFO, head in f0; discarded on restart, flush and error
  always_ff @(posedge clkin) begin
    if (coldres || start || state == FLUSH || state == ERROR) fcnt <= 2'd0;
    else begin
      fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
      if (pop) f0 <= f1;
      if (push && wr_pos == 2'd0) f0 <= wr_data;
      if (push && wr_pos == 2'd1) f1 <= wr_data;
    end
  end
  // Sticky flag for bytes written while the FIFO could not take them
  always_ff @(posedge clkin) begin
    if (coldres || start) overrun <= 1'b0;
    else if (wr_stb && !wr_ready) overrun <= 1'b1;
  end
  // Configuration sequencer and DCLK/DATA0 serialiser
  always_ff @(posedge clkin) begin
    if (coldres) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      phase <= 1'b0;
      shreg <= '0;
      dclk  <= 1'b0;
      data0 <= 1'b0;
    end else if (start) begin
      state <= NCFG;
      cnt   <= '0;
      phase <= 1'b0;
      dclk  <= 1'b0;
      data0 <= 1'b0;
    end else begin
      case (state)
        NCFG: begin
          cnt   <= cnt == NCFG_END ? '0 : cnt + 16'd1;
          state <= cnt == NCFG_END ? WAITST : NCFG;
        end
        WAITST: begin
          if (st_s) state <= LOAD;
          else if (cnt == TMO_END) state <= ERROR;
          else cnt <= cnt + 16'd1;
        end
        LOAD: begin
          if (!st_s) state <= ERROR;
          else if (cd_s) begin
            state <= FLUSH;
            cnt   <= '0;
            idx   <= '0;
            phase <= 1'b0;
            data0 <= 1'b1;
          end else if (pop) begin
            state <= SHIFT;
            shreg <= f0;
            data0 <= f0[0];
            cnt   <= '0;
            idx   <= '0;
            phase <= 1'b0;
          end
        end
        SHIFT, FLUSH: begin
          if (!st_s) begin
            state <= ERROR;
            dclk  <= 1'b0;
          end else if (!half_end) cnt <= cnt + 16'd1;
          else if (!phase) begin
            cnt   <= '0;
            phase <= 1'b1;
            dclk  <= 1'b1;
          end else begin
            cnt   <= '0;
            phase <= 1'b0;
            dclk  <= 1'b0;
            if (state == FLUSH) begin
              if (idx == INIT_END) state <= DONE;
              else idx <= idx + 16'd1;
            end else if (cd_s) begin
              state <= FLUSH;
              idx   <= '0;
              data0 <= 1'b1;
            end else if (idx != 16'd7) begin
              idx   <= idx + 16'd1;
              shreg <= {1'b0, shreg[7:1]};
              data0 <= shreg[1];
            end else if (pop) begin
              idx   <= '0;
              shreg <= f0;
              data0 <= f0[0];
            end else state <= LOAD;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpga_ps_loader.sv
// tb_fpga_ps_loader: directed/randomised bench for the passive-serial loader
module tb_fpga_ps_loader;
  localparam int CLKDIV = 2;
  localparam int NCFG   = 64;
  localparam int TMO    = 100;
  localparam int INIT   = 16;
  logic       clkin = 1'b0;
  logic       coldres = 1'b1;
  logic       start = 1'b0;
  logic       wr_stb = 1'b0;
  logic       status_n = 1'b0;
  logic       conf_done = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, config_n, dclk, data0, busy, done, error;
  logic [7:0] stat;
  int         vectors = 0;
  int         miscompares = 0;
  int         mcyc = 0;
  logic       prev_dclk = 1'b0;
  int         rises[$];
  logic       bits[$];
  logic [7:0] acc[$];

  always #5 clkin = ~clkin;

  fpga_ps_loader #(.CLKDIV(CLKDIV), .NCFG_CYCLES(NCFG), .STATUS_TMO(TMO), .INIT_CLKS(INIT)) dut (
    .clkin(clkin), .coldres(coldres), .start(start), .wr_stb(wr_stb), .wr_data(wr_data),
    .wr_ready(wr_ready), .config_n(config_n), .status_n(status_n), .conf_done(conf_done),
    .dclk(dclk), .data0(data0), .busy(busy), .done(done), .error(error), .stat(stat)
  );

  // Record DATA0 as the FPGA sees it: one bit per DCLK rising edge
  always @(negedge clkin) begin
    mcyc++;
    if (dclk && !prev_dclk) begin
      rises.push_back(mcyc);
      bits.push_back(data0);
    end
    prev_dclk = dclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clkin);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_load(input string tag);
    int n;
    n = 0;
    while (!wr_ready && n < 200) begin
      if (n == 10) status_n = 1'b1;
      step();
      n++;
    end
    chk(tag, wr_ready, 1);
  endtask

  task automatic wait_bits(input int target, input string tag);
    int n;
    n = 0;
    while (bits.size() < target && n < 400) begin
      step();
      n++;
    end
    chk(tag, bits.size() >= target, 1);
  endtask

  task automatic cmp_bytes(input string tag);
    logic [7:0] got;
    chk({tag, "_bitcount"}, bits.size(), 8 * acc.size());
    for (int j = 0; j < acc.size(); j++) begin
      got = 8'h00;
      for (int i = 0; i < 8; i++) if (8 * j + i < bits.size()) got[i] = bits[8 * j + i];
      chk({tag, "_byte"}, got, acc[j]);
    end
  endtask

  // Push every byte of acc whenever the loader is ready, then collect all its bits
  task automatic stream(input string tag);
    int sent, n;
    sent = 0;
    n = 0;
    bits.delete();
    rises.delete();
    while ((sent < acc.size() || bits.size() < 8 * acc.size()) && n < 40 * acc.size() + 100) begin
      if (sent < acc.size() && wr_ready) begin
        wr_stb = 1'b1;
        wr_data = acc[sent];
        sent++;
      end else wr_stb = 1'b0;
      step();
      n++;
    end
    wr_stb = 1'b0;
    cmp_bytes(tag);
  endtask

  initial begin
    int n, bad, zeros, ones, order_bad, low;
    // 1: reset values, nCONFIG width, entry to byte loading
    step(3);
    chk("rst_config_n", config_n, 1);
    chk("rst_dclk", dclk, 0);
    chk("rst_data0", data0, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_stat", stat, 8'h00);
    coldres = 1'b0;
    step();
    pulse_start();
    low = 0;
    while (!config_n && low < 200) begin
      if (low == 10) status_n = 1'b1;
      low++;
      step();
    end
    chk("t1_ncfg_width", low, NCFG);
    chk("t1_waitst_ready", wr_ready, 0);
    chk("t1_waitst_busy", busy, 1);
    step();
    chk("t1_load_ready", wr_ready, 1);
    chk("t1_stat_status", stat[7], 1);
    // 2: continuous stream, LSB first, fixed bytes then random
    acc.delete();
    acc.push_back(8'hA5);
    acc.push_back(8'h3C);
    repeat (4) acc.push_back(8'($urandom));
    stream("t2");
    bad = 0;
    for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != 2 * CLKDIV) bad++;
    chk("t2_dclk_period", bad, 0);
    chk("t2_byte_period", rises.size() > 8 ? rises[8] - rises[0] : -1, 16 * CLKDIV);
    step(5);
    chk("t2_idle_dclk", dclk, 0);
    chk("t2_load_busy", busy, 1);
    // 3: fill FIFO, extra write while not ready is dropped and flagged
    acc.delete();
    bits.delete();
    rises.delete();
    n = 0;
    while (wr_ready && n < 20) begin
      wr_stb = 1'b1;
      wr_data = 8'($urandom);
      acc.push_back(wr_data);
      step();
      n++;
    end
    chk("t3_ready_low", wr_ready, 0);
    chk("t3_fifo_full", stat[1:0], 2);
    wr_data = 8'hEE;
    step();
    wr_stb = 1'b0;
    chk("t3_overrun", stat[5], 1);
    wait_bits(8 * acc.size(), "t3_drain");
    step(20);
    cmp_bytes("t3");
    // 4: CONF_DONE mid-byte ends the bit, then init clocks with DATA0 high
    bits.delete();
    rises.delete();
    wr_stb = 1'b1;
    wr_data = 8'h00;
    step();
    wr_stb = 1'b0;
    wait_bits(3, "t4_shift");
    conf_done = 1'b1;
    n = 0;
    while (!done && n < 300) begin
      step();
      n++;
    end
    chk("t4_done", done, 1);
    zeros = 0;
    ones = 0;
    order_bad = 0;
    foreach (bits[i]) begin
      if (!bits[i]) begin
        zeros++;
        if (ones != 0) order_bad++;
      end else ones++;
    end
    chk("t4_bit_completed", zeros >= 3 && zeros <= 5, 1);
    chk("t4_flush_pulses", ones, INIT);
    chk("t4_order", order_bad, 0);
    chk("t4_busy", busy, 0);
    chk("t4_error", error, 0);
    chk("t4_stat_cd", stat[6], 1);
    step(10);
    chk("t4_dclk_stopped", dclk, 0);
    chk("t4_no_more_pulses", bits.size(), zeros + ones);
    conf_done = 1'b0;
    // 5a: nSTATUS never released -> timeout
    status_n = 1'b0;
    pulse_start();
    chk("t5_done_cleared", done, 0);
    chk("t5_overrun_cleared", stat[5], 0);
    chk("t5_ncfg", config_n, 0);
    n = 0;
    while (!config_n && n < 200) begin
      step();
      n++;
    end
    n = 0;
    while (!error && n < 300) begin
      step();
      n++;
    end
    chk("t5_timeout", n, TMO);
    chk("t5_err_busy", busy, 0);
    chk("t5_err_config_n", config_n, 1);
    // 5b: nSTATUS drop mid-shift
    pulse_start();
    wait_load("t5b_load");
    bits.delete();
    wr_stb = 1'b1;
    wr_data = 8'($urandom);
    step();
    wr_stb = 1'b0;
    wait_bits(3, "t5b_shift");
    status_n = 1'b0;
    n = 0;
    while (!error && n < 20) begin
      step();
      n++;
    end
    chk("t5b_latency", n, 3);
    chk("t5b_dclk", dclk, 0);
    chk("t5b_busy", busy, 0);
    chk("t5b_fifo", stat[1:0], 0);
    // 6a: restart mid-shift with a simultaneous write
    status_n = 1'b1;
    pulse_start();
    wait_load("t6_load");
    bits.delete();
    wr_stb = 1'b1;
    wr_data = 8'($urandom);
    step();
    wr_data = 8'($urandom);
    step();
    wr_stb = 1'b0;
    wait_bits(3, "t6_shift");
    start = 1'b1;
    wr_stb = 1'b1;
    wr_data = 8'($urandom);
    step();
    start = 1'b0;
    wr_stb = 1'b0;
    chk("t6_ncfg", config_n, 0);
    chk("t6_busy", busy, 1);
    chk("t6_fifo_clear", stat[1:0], 0);
    chk("t6_no_overrun", stat[5], 0);
    chk("t6_dclk", dclk, 0);
    chk("t6_ready", wr_ready, 0);
    wait_load("t6_reload");
    acc.delete();
    acc.push_back(8'($urandom));
    stream("t6");
    step(20);
    chk("t6_no_stale", bits.size(), 8);
    // 6b: cold reset mid-shift
    bits.delete();
    wr_stb = 1'b1;
    wr_data = 8'($urandom);
    step();
    wr_stb = 1'b0;
    wait_bits(3, "t6b_shift");
    coldres = 1'b1;
    step();
    chk("t6b_config_n", config_n, 1);
    chk("t6b_dclk", dclk, 0);
    chk("t6b_data0", data0, 0);
    chk("t6b_busy", busy, 0);
    chk("t6b_ready", wr_ready, 0);
    chk("t6b_stat", stat, 8'h00);
    coldres = 1'b0;
    low = 0;
    repeat (10) begin
      step();
      if (!config_n) low++;
    end
    chk("t6b_no_ncfg", low, 0);
    chk("t6b_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
